// File: rtl/cache_mem_arbiter.sv
// Arbitrates ICache/DCache line refills and DCache write-backs
// onto a single word-beat memory bus.
module cache_mem_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int WORD       = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_rd_req,
  input  logic [WORD-1:0]            i_rd_addr,
  output logic                       i_rd_ready,
  output logic [LINE_WORDS*WORD-1:0] i_ret_data,
  input  logic                       d_rd_req,
  input  logic [WORD-1:0]            d_rd_addr,
  output logic                       d_rd_ready,
  output logic [LINE_WORDS*WORD-1:0] d_ret_data,
  input  logic                       d_wr_req,
  input  logic [WORD-1:0]            d_wr_addr,
  input  logic [LINE_WORDS*WORD-1:0] d_wr_data,
  output logic                       d_wr_ready,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [WORD-1:0]            mem_addr,
  output logic [WORD-1:0]            mem_wdata,
  input  logic                       mem_ack,
  input  logic [WORD-1:0]            mem_rdata
);

  localparam int BW  = $clog2(LINE_WORDS);
  localparam int OFF = BW + 2;
  localparam logic [WORD-1:0] ALIGN =
    {{(WORD-OFF){1'b1}}, {OFF{1'b0}}};
  localparam logic [BW-1:0] LAST = BW'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, IRD, DRD, DWR, DONE
  } state_t;

  state_t state, state_n;

  logic                            last_d;
  logic [BW-1:0]                   beat;
  logic [BW-1:0]                   beat_nx;
  logic [LINE_WORDS-1:0][WORD-1:0] line_buf;
  logic [LINE_WORDS-1:0][WORD-1:0] wr_line;
  logic                            grant_w;
  logic                            grant_d;
  logic                            grant_i;
  logic                            beat_ok;
  logic                            last_beat;
  logic [WORD-1:0]                 addr_sel;

  assign beat_nx    = beat + 1'b1;
  assign beat_ok    = mem_req & mem_ack;
  assign last_beat  = beat_ok & (beat == LAST);
  assign i_ret_data = line_buf;
  assign d_ret_data = line_buf;

  // last_d = 1 means the DCache read was served last
  always_comb begin
    grant_w  = d_wr_req;
    grant_d  = ~d_wr_req & d_rd_req
             & (~i_rd_req | ~last_d);
    grant_i  = ~d_wr_req & i_rd_req
             & (~d_rd_req | last_d);
    addr_sel = i_rd_addr;
    unique case (1'b1)
      grant_w: addr_sel = d_wr_addr;
      grant_d: addr_sel = d_rd_addr;
      default: addr_sel = i_rd_addr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          grant_w: state_n = DWR;
          grant_d: state_n = DRD;
          grant_i: state_n = IRD;
          default: state_n = IDLE;
        endcase
      end
      IRD, DRD, DWR: begin
        if (last_beat) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      beat       <= '0;
      line_buf   <= '0;
      wr_line    <= '0;
      last_d     <= 1'b0;
      i_rd_ready <= 1'b0;
      d_rd_ready <= 1'b0;
      d_wr_ready <= 1'b0;
    end else begin
      i_rd_ready <= 1'b0;
      d_rd_ready <= 1'b0;
      d_wr_ready <= 1'b0;
      if (state == IDLE) begin
        if (grant_w | grant_d | grant_i) begin
          mem_req  <= 1'b1;
          mem_we   <= grant_w;
          mem_addr <= addr_sel & ALIGN;
          beat     <= '0;
        end
        if (grant_w) begin
          wr_line   <= d_wr_data;
          mem_wdata <= d_wr_data[WORD-1:0];
        end
        if (grant_d | grant_i) last_d <= grant_d;
      end else if (beat_ok) begin
        beat     <= beat_nx;
        mem_addr <= mem_addr + WORD'(4);
        if (mem_we) mem_wdata <= wr_line[beat_nx];
        else        line_buf[beat] <= mem_rdata;
        if (last_beat) begin
          mem_req    <= 1'b0;
          mem_we     <= 1'b0;
          i_rd_ready <= (state == IRD);
          d_rd_ready <= (state == DRD);
          d_wr_ready <= (state == DWR);
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed literal cases plus
// random traffic checked against a transaction-level model.
module tb_cache_mem_arbiter;

  localparam int LW = 4;
  localparam int W  = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_rd_req, i_rd_ready;
  logic [W-1:0]    i_rd_addr;
  logic [LW*W-1:0] i_ret_data;
  logic            d_rd_req, d_rd_ready;
  logic [W-1:0]    d_rd_addr;
  logic [LW*W-1:0] d_ret_data;
  logic            d_wr_req, d_wr_ready;
  logic [W-1:0]    d_wr_addr;
  logic [LW*W-1:0] d_wr_data;
  logic            mem_req, mem_we, mem_ack;
  logic [W-1:0]    mem_addr, mem_wdata, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.LINE_WORDS(LW), .WORD(W)) dut (
    .clk(clk), .rst(rst),
    .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr),
    .i_rd_ready(i_rd_ready), .i_ret_data(i_ret_data),
    .d_rd_req(d_rd_req), .d_rd_addr(d_rd_addr),
    .d_rd_ready(d_rd_ready), .d_ret_data(d_ret_data),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr),
    .d_wr_data(d_wr_data), .d_wr_ready(d_wr_ready),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string name,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h",
               name, act, exp);
    end
  endtask

  // model: phase 0 idle, 1 beats, 2 ready cycle
  int          m_phase = 0;
  int          m_ch = 0;
  int          m_k = 0;
  logic [31:0] m_base = 0;
  logic [31:0] m_wl [LW];
  logic [31:0] m_rl [LW];
  bit          m_last_d = 0;
  bit          m_post_rst = 1;

  function automatic logic [LW*W-1:0] pack_rl();
    logic [LW*W-1:0] r;
    for (int i = 0; i < LW; i++) r[32*i +: 32] = m_rl[i];
    return r;
  endfunction

  initial for (int i = 0; i < LW; i++) m_rl[i] = 0;

  always @(negedge clk) begin
    if (check_en) begin
      chk("mem_req", mem_req, m_phase == 1);
      chk("mem_we", mem_we, m_phase == 1 && m_ch == 2);
      chk("i_rd_ready", i_rd_ready,
          m_phase == 2 && m_ch == 0);
      chk("d_rd_ready", d_rd_ready,
          m_phase == 2 && m_ch == 1);
      chk("d_wr_ready", d_wr_ready,
          m_phase == 2 && m_ch == 2);
      if (m_phase == 1) begin
        chk("mem_addr", mem_addr, m_base + 32'(4 * m_k));
        if (m_ch == 2)
          chk("mem_wdata", mem_wdata, m_wl[m_k]);
      end
      if (m_post_rst) begin
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
      end
      if (!(m_phase == 1 && m_ch != 2)) begin
        chk("i_ret_data", i_ret_data, pack_rl());
        chk("d_ret_data", d_ret_data, pack_rl());
      end
      if (rst) begin
        m_phase = 0;
        m_last_d = 0;
        m_post_rst = 1;
        for (int i = 0; i < LW; i++) m_rl[i] = 0;
      end else begin
        m_post_rst = 0;
        case (m_phase)
          0: if (i_rd_req || d_rd_req || d_wr_req) begin
            if (d_wr_req) begin
              m_ch = 2;
              m_base = d_wr_addr;
            end else if (d_rd_req && (!i_rd_req || !m_last_d)) begin
              m_ch = 1;
              m_base = d_rd_addr;
            end else begin
              m_ch = 0;
              m_base = i_rd_addr;
            end
            m_base = m_base & 32'hFFFF_FFF0;
            for (int i = 0; i < LW; i++)
              m_wl[i] = d_wr_data[32*i +: 32];
            if (m_ch != 2) m_last_d = (m_ch == 1);
            m_k = 0;
            m_phase = 1;
          end
          1: if (mem_ack) begin
            if (m_ch != 2) m_rl[m_k] = mem_rdata;
            m_k++;
            if (m_k == LW) m_phase = 2;
          end
          default: m_phase = 0;
        endcase
      end
    end
  end

  task automatic reset_dut();
    rst = 1'b1;
    i_rd_req = 0;
    d_rd_req = 0;
    d_wr_req = 0;
    mem_ack = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  function automatic logic nxt_req(input logic cur,
                                   input logic drop,
                                   input int odds);
    if (drop) return 1'b0;
    if (!cur) return $urandom_range(0, odds - 1) == 0;
    return $urandom_range(0, 49) != 0;
  endfunction

  bit i_drop, d_drop, w_drop;

  initial begin
    rst = 1'b1;
    i_rd_req = 0; d_rd_req = 0; d_wr_req = 0;
    i_rd_addr = 0; d_rd_addr = 0; d_wr_addr = 0;
    d_wr_data = 0; mem_ack = 0; mem_rdata = 0;
    @(posedge clk);
    #1;
    check_en = 1'b1;

    reset_dut();
    i_rd_req = 1;
    i_rd_addr = 32'h1C00_0014;
    mem_ack = 1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1;
      if (c <= 4) begin
        chk("r28_req", mem_req, 1);
        chk("r28_we", mem_we, 0);
        chk("r28_addr", mem_addr,
            32'h1C00_0010 + 4 * (c - 1));
      end
      chk("r28_rdy", i_rd_ready, c == 5);
      if (c == 5)
        chk("r28_line", i_ret_data,
            {32'hA000_0004, 32'hA000_0003,
             32'hA000_0002, 32'hA000_0001});
      mem_rdata = 32'hA000_0000 + c;
      if (c == 6) i_rd_req = 0;
    end

    reset_dut();
    d_wr_req = 1;
    d_rd_req = 1;
    d_wr_addr = 32'h0000_8008;
    d_rd_addr = 32'h0000_9000;
    d_wr_data = {32'hD000_0003, 32'hD000_0002,
                 32'hD000_0001, 32'hD000_0000};
    mem_ack = 1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      if (c <= 4) begin
        chk("r29_wwe", mem_we, 1);
        chk("r29_waddr", mem_addr, 32'h8000 + 4 * (c - 1));
        chk("r29_wdata", mem_wdata,
            32'hD000_0000 + (c - 1));
      end
      if (c >= 7 && c <= 10) begin
        chk("r29_rwe", mem_we, 0);
        chk("r29_raddr", mem_addr, 32'h9000 + 4 * (c - 7));
      end
      chk("r29_wrdy", d_wr_ready, c == 5);
      chk("r29_rrdy", d_rd_ready, c == 11);
      if (c == 11)
        chk("r29_line", d_ret_data,
            {32'hB000_000A, 32'hB000_0009,
             32'hB000_0008, 32'hB000_0007});
      mem_rdata = 32'hB000_0000 + c;
      if (c == 6) d_wr_req = 0;
      if (c == 12) d_rd_req = 0;
    end

    reset_dut();
    i_rd_req = 1;
    d_rd_req = 1;
    mem_ack = 1;
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk);
      #1;
      if (c % 6 == 5) begin
        chk("r30_d", d_rd_ready, (c / 6) % 2 == 0);
        chk("r30_i", i_rd_ready, (c / 6) % 2 == 1);
      end
      mem_rdata = $urandom;
      if (c == 24) begin
        i_rd_req = 0;
        d_rd_req = 0;
      end
    end

    reset_dut();
    i_rd_req = 1;
    i_rd_addr = 32'h0000_4444;
    mem_ack = 0;
    for (int c = 1; c <= 18; c++) begin
      @(posedge clk);
      #1;
      if (c <= 16) begin
        chk("r31_req", mem_req, 1);
        chk("r31_addr", mem_addr,
            32'h4440 + 4 * ((c - 1) / 4));
      end
      chk("r31_rdy", i_rd_ready, c == 17);
      mem_ack = (c % 4 == 0);
      mem_rdata = $urandom;
      if (c == 18) i_rd_req = 0;
    end

    reset_dut();
    i_rd_req = 1;
    i_rd_addr = 32'h3000_0024;
    mem_ack = 1;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk);
      #1;
      chk("r32_rdy", i_rd_ready, c == 10);
      if (c == 3) chk("r32_b2", mem_addr, 32'h3000_0028);
      if (c == 4 || c == 5) begin
        chk("r32_req", mem_req, 0);
        chk("r32_addr", mem_addr, 0);
      end
      if (c == 6) chk("r32_re", mem_addr, 32'h2000_0000);
      mem_rdata = $urandom;
      rst = (c == 3);
      if (c == 3) i_rd_req = 0;
      if (c == 5) begin
        i_rd_req = 1;
        i_rd_addr = 32'h2000_0008;
      end
      if (c == 11) i_rd_req = 0;
    end

    i_drop = 0; d_drop = 0; w_drop = 0;
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 299) == 0);
      mem_ack = ($urandom_range(0, 9) < 7);
      mem_rdata = $urandom;
      i_rd_addr = $urandom;
      d_rd_addr = $urandom;
      d_wr_addr = $urandom;
      for (int k = 0; k < LW; k++)
        d_wr_data[32*k +: 32] = $urandom;
      i_rd_req = nxt_req(i_rd_req, i_drop, 4);
      d_rd_req = nxt_req(d_rd_req, d_drop, 4);
      d_wr_req = nxt_req(d_wr_req, w_drop, 8);
      i_drop = i_rd_ready;
      d_drop = d_rd_ready;
      w_drop = d_wr_ready;
    end

    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
